// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial adder/subtractor with valid/ready handshakes; SERIAL_ADDSUB_SAT_EN enables signed saturation
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt, r_fin;
  logic [CW-1:0] cnt;
  logic sub_r, c, ai, bi, s, c_nxt, ovf, last;
  always_comb begin
    ai = a_sh[0];
    bi = b_sh[0];
    s = ai ^ bi ^ c;
    c_nxt = sub_r ? (~ai & bi | ~(ai ^ bi) & c) : (ai & bi | c & (ai ^ bi));
    ovf = sub_r ? ((ai != bi) && (s != ai)) : (c ^ c_nxt);
    last = cnt == CW'(WIDTH - 1);
    r_nxt = {s, r_sh[WIDTH-1:1]};
`ifdef SERIAL_ADDSUB_SAT_EN
    r_fin = ovf ? {ai, {(WIDTH-1){~ai}}} : r_nxt;
`else
    r_fin = r_nxt;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cnt <= '0;
      c <= 1'b0;
      sub_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= a;
          b_sh <= b;
          sub_r <= sub;
          c <= 1'b0;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= r_nxt;
          c <= c_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= r_fin;
            carry_out <= c_nxt;
            overflow <= ovf;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
